vstu_burst_tracker: RTL and testbench
=====================================

VSTU_BURST_TRACKER -- requirements
Module: vstu_burst_tracker

Interface
REQ-001 SHALL have parameter NrVInsn, default 8: number of vector instruction IDs; IdWidth = idx_width(NrVInsn).
REQ-002 SHALL have parameter QueueDepth, default 4: number of store instructions tracked at once.
REQ-003 SHALL have parameter BurstCntWidth, default 8: width of the per-instruction burst counters.
REQ-004 SHALL have one clock and a synchronous, active-low reset; ports clk_i and rst_ni.
REQ-005 clk_i  input  1  clock; all state updates on its rising edge.
REQ-006 rst_ni  input  1  synchronous active-low reset.
REQ-007 insn_valid_i  input  1  store unit offers a newly accepted store instruction.
REQ-008 insn_id_i  input  IdWidth  ID of the offered instruction.
REQ-009 insn_ready_o  output  1  tracker can accept an instruction.
REQ-010 aw_valid_i  input  1  address generator issues one AW burst for the oldest not-fully-issued instruction.
REQ-011 aw_last_i  input  1  qualifies aw_valid_i; this burst is the instruction's final burst.
REQ-012 aw_ready_o  output  1  tracker accepts the AW burst.
REQ-013 b_valid_i  input  1  AXI B response valid.
REQ-014 b_resp_i  input  2  AXI B response code.
REQ-015 b_ready_o  output  1  B response accepted.
REQ-016 done_valid_o  output  1  one-cycle pulse: an instruction has all of its B responses.
REQ-017 done_id_o  output  IdWidth  ID of the completed instruction.
REQ-018 done_err_o  output  1  at least one B response of that instruction had b_resp_i[1]=1.
REQ-019 pending_o  output  1  at least one entry is occupied.

Function
REQ-020 SHALL hold a circular queue of QueueDepth entries, each {id, aw_cnt, b_cnt, all_issued, err}, with accept, issue and commit pointers that wrap from QueueDepth-1 to 0.
REQ-021 insn_ready_o SHALL be 1 iff the registered occupancy is < QueueDepth; a same-cycle pop SHALL NOT enable a push when the queue is full.
REQ-022 On an insn handshake SHALL write {insn_id_i, 0, 0, 0, 0} at the accept pointer, then advance the accept pointer and increment occupancy.
REQ-023 aw_ready_o SHALL be 1 iff an entry that is not all_issued exists at the issue pointer and its aw_cnt < 2^BurstCntWidth-1.
REQ-024 On an AW handshake SHALL increment aw_cnt of the issue entry.
REQ-025 If aw_last_i=1 on an AW handshake, SHALL also set all_issued and advance the issue pointer.
REQ-026 b_ready_o SHALL be 1 iff the commit entry is occupied and its registered b_cnt < aw_cnt. Consequently a B response is never accepted in the cycle its AW is accepted.
REQ-027 On a B handshake SHALL increment b_cnt of the commit entry and OR b_resp_i[1] into its err bit.
REQ-028 On a B handshake where next-state all_issued=1 and b_cnt==aw_cnt, SHALL pop the commit entry: advance the commit pointer and decrement occupancy.
REQ-029 In the cycle after that pop, done_valid_o SHALL be 1, with done_id_o and done_err_o taken from the popped entry; otherwise done_valid_o=0.
REQ-030 done_id_o and done_err_o SHALL hold their last values while done_valid_o=0.
REQ-031 Push, AW, B and pop in the same cycle SHALL all take effect, with occupancy = q + push - pop.
REQ-032 The issue entry and the commit entry may be the same entry; the counter updates in REQ-024 and REQ-027 SHALL both apply in that cycle.
REQ-033 aw_valid_i with aw_ready_o=0 SHALL be ignored. A simulation assertion SHALL flag aw_valid_i=1 when no un-issued entry exists.
REQ-034 pending_o SHALL be 1 iff registered occupancy != 0.

Reset
REQ-035 With rst_ni=0 at a clock edge, SHALL clear all pointers, occupancy, counters and entries.
REQ-036 Under reset, done_valid_o, done_id_o, done_err_o and pending_o SHALL be 0; insn_ready_o SHALL be 1.
REQ-037 Reset asserted mid-operation SHALL discard all tracked instructions; no done pulse SHALL be emitted for them.

Verification
REQ-038 Single instruction: id 3, 2 AW bursts (second with last), 2 OKAY B -> done_valid_o pulses once the cycle after the 2nd B, done_id_o=3, done_err_o=0.
REQ-039 Full queue: push ids 0-3 with no AW -> insn_ready_o=0. Complete id 0 (1 burst, 1 B) while offering id 4 in the pop cycle -> id 4 is not accepted that cycle and is accepted the next cycle.
REQ-040 Error: id 5, 3 bursts, B responses OKAY, SLVERR, OKAY -> done_err_o=1 with done_id_o=5.
REQ-041 Back-pressure: B valid before any AW -> b_ready_o=0 until the cycle after the AW handshake. B during the AW cycle -> not accepted.
REQ-042 Pipelined: ids 1 and 2 (2 bursts each), AW of id 2 overlapping B of id 1 -> done pulses in order 1 then 2. Pointers wrap correctly after 6 total instructions.
REQ-043 Saturation and reset: with BurstCntWidth=2, 3 AW bursts without last -> aw_ready_o=0. Assert rst_ni=0 mid-stream -> pending_o=0, no done pulse afterwards.

Source files
------------

// File: rtl/vstu_burst_tracker.sv
// Vector store unit AXI burst tracker: counts the AW bursts and B responses of each
// in-flight store instruction and reports completion and error status in order.
module vstu_burst_tracker #(
  parameter int unsigned NrVInsn       = 8,
  parameter int unsigned QueueDepth    = 4,
  parameter int unsigned BurstCntWidth = 8,
  localparam int unsigned IdWidth      = (NrVInsn > 1) ? $clog2(NrVInsn) : 1
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               insn_valid_i,
  input  logic [IdWidth-1:0] insn_id_i,
  output logic               insn_ready_o,
  input  logic               aw_valid_i,
  input  logic               aw_last_i,
  output logic               aw_ready_o,
  input  logic               b_valid_i,
  input  logic [1:0]         b_resp_i,
  output logic               b_ready_o,
  output logic               done_valid_o,
  output logic [IdWidth-1:0] done_id_o,
  output logic               done_err_o,
  output logic               pending_o
);

  localparam int unsigned PtrWidth = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned OccWidth = $clog2(QueueDepth + 1);

  typedef logic [PtrWidth-1:0] ptr_t;
  typedef logic [OccWidth-1:0] occ_t;

  typedef struct packed {
    logic [IdWidth-1:0]       id;
    logic [BurstCntWidth-1:0] aw_cnt;
    logic [BurstCntWidth-1:0] b_cnt;
    logic                     all_issued;
    logic                     err;
    logic                     valid;
  } entry_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(QueueDepth - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  entry_t q_q [QueueDepth];
  entry_t q_d [QueueDepth];
  ptr_t   acc_ptr_q, acc_ptr_d;
  ptr_t   iss_ptr_q, iss_ptr_d;
  ptr_t   cmt_ptr_q, cmt_ptr_d;
  occ_t   occ_q, occ_d;
  logic   done_valid_q, done_err_q;
  logic [IdWidth-1:0] done_id_q;

  entry_t iss_e, cmt_e, popped;
  logic   push, aw_hs, b_hs, pop;

  assign iss_e = q_q[iss_ptr_q];
  assign cmt_e = q_q[cmt_ptr_q];

  assign insn_ready_o = occ_q < occ_t'(QueueDepth);
  assign aw_ready_o   = iss_e.valid && !iss_e.all_issued && (iss_e.aw_cnt != '1);
  assign b_ready_o    = cmt_e.valid && (cmt_e.b_cnt < cmt_e.aw_cnt);
  assign pending_o    = occ_q != '0;

  assign push  = insn_valid_i && insn_ready_o;
  assign aw_hs = aw_valid_i && aw_ready_o;
  assign b_hs  = b_valid_i && b_ready_o;

  // Updates are applied in order AW -> B -> pop -> push on a working copy so that
  // an issue entry that is also the commit entry sees both counter increments.
  always_comb begin
    q_d       = q_q;
    acc_ptr_d = acc_ptr_q;
    iss_ptr_d = iss_ptr_q;
    cmt_ptr_d = cmt_ptr_q;
    occ_d     = occ_q;
    pop       = 1'b0;
    popped    = '0;

    if (aw_hs) begin
      q_d[iss_ptr_q].aw_cnt = q_q[iss_ptr_q].aw_cnt + 1'b1;
      if (aw_last_i) begin
        q_d[iss_ptr_q].all_issued = 1'b1;
        iss_ptr_d = ptr_inc(iss_ptr_q);
      end
    end

    if (b_hs) begin
      q_d[cmt_ptr_q].b_cnt = q_d[cmt_ptr_q].b_cnt + 1'b1;
      q_d[cmt_ptr_q].err   = q_d[cmt_ptr_q].err | b_resp_i[1];
      if (q_d[cmt_ptr_q].all_issued && (q_d[cmt_ptr_q].b_cnt == q_d[cmt_ptr_q].aw_cnt)) begin
        pop            = 1'b1;
        popped         = q_d[cmt_ptr_q];
        q_d[cmt_ptr_q] = '0;
        cmt_ptr_d      = ptr_inc(cmt_ptr_q);
      end
    end

    if (push) begin
      q_d[acc_ptr_q]       = '0;
      q_d[acc_ptr_q].id    = insn_id_i;
      q_d[acc_ptr_q].valid = 1'b1;
      acc_ptr_d            = ptr_inc(acc_ptr_q);
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + occ_t'(1);
      2'b01:   occ_d = occ_q - occ_t'(1);
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < QueueDepth; i++) q_q[i] <= '0;
      acc_ptr_q    <= '0;
      iss_ptr_q    <= '0;
      cmt_ptr_q    <= '0;
      occ_q        <= '0;
      done_valid_q <= 1'b0;
      done_id_q    <= '0;
      done_err_q   <= 1'b0;
    end else begin
      q_q          <= q_d;
      acc_ptr_q    <= acc_ptr_d;
      iss_ptr_q    <= iss_ptr_d;
      cmt_ptr_q    <= cmt_ptr_d;
      occ_q        <= occ_d;
      done_valid_q <= pop;
      if (pop) begin
        done_id_q  <= popped.id;
        done_err_q <= popped.err;
      end
    end
  end

  assign done_valid_o = done_valid_q;
  assign done_id_o    = done_id_q;
  assign done_err_o   = done_err_q;

  aw_without_insn: assert property (@(posedge clk_i) disable iff (!rst_ni)
    aw_valid_i |-> (iss_e.valid && !iss_e.all_issued))
    else $error("aw_valid_i asserted with no un-issued store instruction");

endmodule

// File: tb/tb_vstu_burst_tracker.sv
// Directed bench for vstu_burst_tracker: default instance plus a 2-bit burst counter
// instance sharing the same stimulus for the saturation case.
module tb_vstu_burst_tracker;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  logic       insn_valid_i;
  logic [2:0] insn_id_i;
  logic       aw_valid_i, aw_last_i;
  logic       b_valid_i;
  logic [1:0] b_resp_i;

  logic       insn_ready, aw_ready, b_ready, done_valid, done_err, pending;
  logic [2:0] done_id;
  logic       s_insn_ready, s_aw_ready, s_b_ready, s_done_valid, s_done_err, s_pending;
  logic [2:0] s_done_id;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  vstu_burst_tracker #(.NrVInsn(8), .QueueDepth(4), .BurstCntWidth(8)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .insn_valid_i(insn_valid_i), .insn_id_i(insn_id_i), .insn_ready_o(insn_ready),
    .aw_valid_i(aw_valid_i), .aw_last_i(aw_last_i), .aw_ready_o(aw_ready),
    .b_valid_i(b_valid_i), .b_resp_i(b_resp_i), .b_ready_o(b_ready),
    .done_valid_o(done_valid), .done_id_o(done_id), .done_err_o(done_err),
    .pending_o(pending)
  );

  vstu_burst_tracker #(.NrVInsn(8), .QueueDepth(4), .BurstCntWidth(2)) dut_sat (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .insn_valid_i(insn_valid_i), .insn_id_i(insn_id_i), .insn_ready_o(s_insn_ready),
    .aw_valid_i(aw_valid_i), .aw_last_i(aw_last_i), .aw_ready_o(s_aw_ready),
    .b_valid_i(b_valid_i), .b_resp_i(b_resp_i), .b_ready_o(s_b_ready),
    .done_valid_o(s_done_valid), .done_id_o(s_done_id), .done_err_o(s_done_err),
    .pending_o(s_pending)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    insn_valid_i = 1'b0;
    aw_valid_i   = 1'b0;
    aw_last_i    = 1'b0;
    b_valid_i    = 1'b0;
    b_resp_i     = 2'b00;
  endtask

  initial begin
    rst_ni    = 1'b0;
    insn_id_i = '0;
    idle();
    cyc();
    cyc();

    // Reset state
    check("rst_done_valid", done_valid, 0);
    check("rst_done_id", done_id, 0);
    check("rst_done_err", done_err, 0);
    check("rst_pending", pending, 0);
    check("rst_insn_ready", insn_ready, 1);
    check("rst_aw_ready", aw_ready, 0);
    check("rst_b_ready", b_ready, 0);
    rst_ni = 1'b1;
    cyc();

    // Single instruction: id 3, two bursts, two OKAY responses
    insn_valid_i = 1'b1; insn_id_i = 3'd3;
    check("t1_insn_ready", insn_ready, 1);
    cyc();
    idle();
    check("t1_pending", pending, 1);
    check("t1_aw_ready", aw_ready, 1);
    check("t1_b_ready_pre", b_ready, 0);
    aw_valid_i = 1'b1;
    cyc();
    check("t1_b_ready_after_aw", b_ready, 1);
    aw_last_i = 1'b1; b_valid_i = 1'b1;
    cyc();
    idle();
    check("t1_aw_ready_issued", aw_ready, 0);
    check("t1_b_ready_second", b_ready, 1);
    check("t1_no_early_done", done_valid, 0);
    b_valid_i = 1'b1;
    cyc();
    idle();
    check("t1_done_valid", done_valid, 1);
    check("t1_done_id", done_id, 3);
    check("t1_done_err", done_err, 0);
    check("t1_pending_empty", pending, 0);
    cyc();
    check("t1_done_pulse_end", done_valid, 0);
    check("t1_done_id_hold", done_id, 3);

    // Full queue and no push on a same-cycle pop
    for (int i = 0; i < 4; i++) begin
      insn_valid_i = 1'b1; insn_id_i = 3'(i);
      cyc();
    end
    idle();
    check("t2_full_insn_ready", insn_ready, 0);
    check("t2_full_aw_ready", aw_ready, 1);
    aw_valid_i = 1'b1; aw_last_i = 1'b1;
    cyc();
    idle();
    b_valid_i = 1'b1; insn_valid_i = 1'b1; insn_id_i = 3'd4;
    check("t2_pop_cycle_insn_ready", insn_ready, 0);
    cyc();
    b_valid_i = 1'b0;
    check("t2_done_id0_valid", done_valid, 1);
    check("t2_done_id0", done_id, 0);
    check("t2_insn_ready_after_pop", insn_ready, 1);
    cyc();
    idle();
    check("t2_refull_insn_ready", insn_ready, 0);
    for (int k = 1; k <= 4; k++) begin
      aw_valid_i = 1'b1; aw_last_i = 1'b1;
      cyc();
      idle();
      b_valid_i = 1'b1;
      cyc();
      idle();
      check("t2_drain_valid", done_valid, 1);
      check("t2_drain_id", done_id, 32'(k));
    end
    check("t2_drained_pending", pending, 0);
    check("t2_drained_insn_ready", insn_ready, 1);

    // Error accumulation: id 5, three bursts, OKAY/SLVERR/OKAY
    insn_valid_i = 1'b1; insn_id_i = 3'd5;
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      aw_valid_i = 1'b1; aw_last_i = (i == 2);
      cyc();
    end
    idle();
    for (int i = 0; i < 3; i++) begin
      b_valid_i = 1'b1; b_resp_i = (i == 1) ? 2'b10 : 2'b00;
      cyc();
      if (i == 1) check("t3_no_done_mid", done_valid, 0);
    end
    idle();
    check("t3_done_valid", done_valid, 1);
    check("t3_done_id", done_id, 5);
    check("t3_done_err", done_err, 1);

    // B back-pressure before and during the AW handshake
    insn_valid_i = 1'b1; insn_id_i = 3'd6;
    cyc();
    idle();
    b_valid_i = 1'b1;
    check("t4_b_ready_no_aw", b_ready, 0);
    cyc();
    check("t4_b_ready_still_0", b_ready, 0);
    aw_valid_i = 1'b1; aw_last_i = 1'b1;
    check("t4_b_ready_aw_cycle", b_ready, 0);
    check("t4_aw_ready", aw_ready, 1);
    cyc();
    aw_valid_i = 1'b0; aw_last_i = 1'b0;
    check("t4_no_done_after_aw", done_valid, 0);
    check("t4_b_ready_after_aw", b_ready, 1);
    cyc();
    idle();
    check("t4_done_valid", done_valid, 1);
    check("t4_done_id", done_id, 6);
    check("t4_done_err", done_err, 0);

    // Pipelined: AW of id 2 overlaps B of id 1
    insn_valid_i = 1'b1; insn_id_i = 3'd1;
    cyc();
    insn_id_i = 3'd2;
    cyc();
    idle();
    aw_valid_i = 1'b1;
    cyc();
    aw_last_i = 1'b1; b_valid_i = 1'b1;
    cyc();
    aw_last_i = 1'b0;
    cyc();
    check("t5_done1_valid", done_valid, 1);
    check("t5_done1_id", done_id, 1);
    aw_last_i = 1'b1;
    check("t5_b_ready_id2", b_ready, 1);
    cyc();
    aw_valid_i = 1'b0; aw_last_i = 1'b0;
    check("t5_no_done_between", done_valid, 0);
    cyc();
    idle();
    check("t5_done2_valid", done_valid, 1);
    check("t5_done2_id", done_id, 2);
    check("t5_empty", pending, 0);

    // Saturation with 2-bit counters, then reset mid-stream
    insn_valid_i = 1'b1; insn_id_i = 3'd7;
    cyc();
    idle();
    check("t6_sat_aw_ready_0", s_aw_ready, 1);
    aw_valid_i = 1'b1;
    cyc();
    check("t6_sat_aw_ready_1", s_aw_ready, 1);
    cyc();
    check("t6_sat_aw_ready_2", s_aw_ready, 1);
    cyc();
    check("t6_sat_aw_ready_3", s_aw_ready, 0);
    check("t6_wide_aw_ready_3", aw_ready, 1);
    cyc();
    aw_valid_i = 1'b0;
    check("t6_sat_still_blocked", s_aw_ready, 0);
    check("t6_sat_pending", s_pending, 1);
    rst_ni = 1'b0;
    cyc();
    check("t6_rst_pending", pending, 0);
    check("t6_rst_sat_pending", s_pending, 0);
    check("t6_rst_insn_ready", s_insn_ready, 1);
    check("t6_rst_done_id", done_id, 0);
    rst_ni = 1'b1;
    b_valid_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      check("t6_post_rst_done", done_valid, 0);
      check("t6_post_rst_sat_done", s_done_valid, 0);
      check("t6_post_rst_b_ready", s_b_ready, 0);
    end
    idle();
    cyc();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
